// File: rtl/spi_cmd_pkg.sv
// Shared opcode and FSM state encodings for the SPI command decoder.
package spi_cmd_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LED  = 4'h1,
    OP_LDA  = 4'h2,
    OP_LDB  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_DISP = 4'h9,
    OP_CLR  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OP1 = 2'd1,
    WAIT_OP2 = 2'd2
  } state_e;

endpackage

// File: rtl/spi_cmd_decoder_alu.sv
// Combinational 4-bit ALU; bit 4 of the result carries carry (ADD) or borrow (SUB).
module nibble_alu
  import spi_cmd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  opcode_e    op,
  output logic [4:0] result,
  output logic       zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      // 5-bit wrap leaves bit 4 set exactly when a < b
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_XOR:  result = {1'b0, a ^ b};
      default: result = '0;
    endcase
  end

  assign zero = (result[3:0] == 4'h0);

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses the SPI nibble stream into opcode/operand commands driving LED, ALU and display registers.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] nibble_in,
  input  logic       nibble_valid_in,
  output logic [3:0] led_out,
  output logic [4:0] result_out,
  output logic       zero_out,
  output logic [7:0] display_out,
  output logic       cmd_done_out,
  output logic       error_out,
  output logic       busy_out
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  opcode_e       cur_op_q, cur_op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic [3:0]    disp_hi_q, disp_hi_d;
  logic [3:0]    led_q, led_d;
  logic [4:0]    result_q, result_d;
  logic          zero_q, zero_d;
  logic [7:0]    display_q, display_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  opcode_e    nib_op;
  logic [4:0] alu_result;
  logic       alu_zero;

  assign nib_op = opcode_e'(nibble_in);

  nibble_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (nib_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d   = state_q;
    cur_op_d  = cur_op_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    disp_hi_d = disp_hi_q;
    led_d     = led_q;
    result_d  = result_q;
    zero_d    = zero_q;
    display_d = display_q;
    done_d    = 1'b0;
    error_d   = error_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (nibble_valid_in) begin
          case (nib_op)
            OP_NOP: done_d = 1'b1;
            OP_LED, OP_LDA, OP_LDB, OP_DISP: begin
              state_d  = WAIT_OP1;
              cur_op_d = nib_op;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              result_d = alu_result;
              zero_d   = alu_zero;
              done_d   = 1'b1;
            end
            OP_CLR: begin
              a_d       = '0;
              b_d       = '0;
              led_d     = '0;
              result_d  = '0;
              display_d = '0;
              error_d   = 1'b0;
              zero_d    = 1'b1;
              done_d    = 1'b1;
            end
            default: error_d = 1'b1;
          endcase
        end
      end

      WAIT_OP1, WAIT_OP2: begin
        // A strobe takes priority over a timeout landing in the same cycle
        if (nibble_valid_in) begin
          cnt_d = '0;
          if (state_q == WAIT_OP2) begin
            display_d = {disp_hi_q, nibble_in};
            state_d   = IDLE;
            done_d    = 1'b1;
          end else begin
            case (cur_op_q)
              OP_LED:  led_d = nibble_in;
              OP_LDA:  a_d   = nibble_in;
              OP_LDB:  b_d   = nibble_in;
              OP_DISP: disp_hi_d = nibble_in;
              default: ;
            endcase
            if (cur_op_q == OP_DISP) begin
              state_d = WAIT_OP2;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_op_q  <= OP_NOP;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      disp_hi_q <= '0;
      led_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      display_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_op_q  <= cur_op_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      disp_hi_q <= disp_hi_d;
      led_q     <= led_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      display_q <= display_d;
      done_q    <= done_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign led_out      = led_q;
  assign result_out   = result_q;
  assign zero_out     = zero_q;
  assign display_out  = display_q;
  assign cmd_done_out = done_q;
  assign error_out    = error_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed plus randomized bench for spi_cmd_decoder against a command-level reference model.
module tb_spi_cmd_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] nibble_in = '0;
  logic       nibble_valid_in = 1'b0;
  logic [3:0] led_out;
  logic [4:0] result_out;
  logic       zero_out;
  logic [7:0] display_out;
  logic       cmd_done_out;
  logic       error_out;
  logic       busy_out;

  int total = 0;
  int bad = 0;

  spi_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .nibble_in       (nibble_in),
    .nibble_valid_in (nibble_valid_in),
    .led_out         (led_out),
    .result_out      (result_out),
    .zero_out        (zero_out),
    .display_out     (display_out),
    .cmd_done_out    (cmd_done_out),
    .error_out       (error_out),
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;

  // Reference model: a pending command plus the operands collected so far
  int m_led, m_res, m_zero, m_disp, m_done, m_err, m_a, m_b;
  int pend_op, need, got, first, quiet;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_led = 0; m_res = 0; m_zero = 1; m_disp = 0; m_done = 0; m_err = 0;
    m_a = 0; m_b = 0; pend_op = -1; need = 0; got = 0; first = 0; quiet = 0;
  endtask

  task automatic model_step(input bit v, input int n);
    m_done = 0;
    if (v) begin
      quiet = 0;
      if (pend_op < 0) begin
        if (n == 0) m_done = 1;
        else if (n >= 1 && n <= 3) begin pend_op = n; need = 1; got = 0; end
        else if (n == 9) begin pend_op = 9; need = 2; got = 0; end
        else if (n >= 4 && n <= 8) begin
          case (n)
            4: m_res = m_a + m_b;
            5: m_res = (m_a - m_b + 32) % 32;
            6: m_res = m_a & m_b;
            7: m_res = m_a | m_b;
            default: m_res = m_a ^ m_b;
          endcase
          m_zero = ((m_res % 16) == 0);
          m_done = 1;
        end else if (n == 15) begin
          m_a = 0; m_b = 0; m_led = 0; m_res = 0; m_disp = 0; m_err = 0; m_zero = 1;
          m_done = 1;
        end else m_err = 1;
      end else begin
        got++;
        if (got == 1) first = n;
        if (got == need) begin
          case (pend_op)
            1: m_led = n;
            2: m_a = n;
            3: m_b = n;
            default: m_disp = first * 16 + n;
          endcase
          m_done = 1;
          pend_op = -1;
        end
      end
    end else if (pend_op >= 0) begin
      quiet++;
      if (quiet == T) begin
        pend_op = -1;
        m_err = 1;
        quiet = 0;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else model_step(nibble_valid_in, int'(nibble_in));
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("led", int'(led_out), m_led);
      chk("result", int'(result_out), m_res);
      chk("zero", int'(zero_out), m_zero);
      chk("display", int'(display_out), m_disp);
      chk("done", int'(cmd_done_out), m_done);
      chk("error", int'(error_out), m_err);
      chk("busy", int'(busy_out), int'(pend_op >= 0));
    end
  end

  // Called at posedge+1; inputs are sampled at the next posedge
  task automatic drive(input bit v, input int n);
    nibble_valid_in = v;
    nibble_in = 4'(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_led", int'(led_out), 0);
    chk("rst_result", int'(result_out), 0);
    chk("rst_zero", int'(zero_out), 1);
    chk("rst_display", int'(display_out), 0);
    chk("rst_done", int'(cmd_done_out), 0);
    chk("rst_error", int'(error_out), 0);
    chk("rst_busy", int'(busy_out), 0);

    drive(1, 1);
    chk("led_busy", int'(busy_out), 1);
    drive(1, 10);
    chk("led_val", int'(led_out), 10);
    chk("led_done", int'(cmd_done_out), 1);
    chk("led_idle", int'(busy_out), 0);
    drive(0, 0);
    chk("led_done_once", int'(cmd_done_out), 0);

    drive(1, 2); drive(1, 9); drive(1, 3); drive(1, 8);
    drive(1, 4);
    chk("add_res", int'(result_out), 'h11);
    chk("add_zero", int'(zero_out), 0);
    drive(1, 5);
    chk("sub_res", int'(result_out), 'h01);
    drive(1, 2); drive(1, 3); drive(1, 5);
    chk("sub_borrow", int'(result_out), 'h1B);
    drive(0, 0);

    drive(1, 9);
    chk("disp_hold0", int'(display_out), 0);
    drive(1, 5);
    chk("disp_hold1", int'(display_out), 0);
    drive(1, 12);
    chk("disp_val", int'(display_out), 'h5C);
    chk("disp_done", int'(cmd_done_out), 1);

    drive(1, 9); drive(1, 3);
    repeat (T - 1) drive(0, 0);
    chk("to_not_yet", int'(busy_out), 1);
    chk("to_no_err_yet", int'(error_out), 0);
    drive(0, 0);
    chk("to_idle", int'(busy_out), 0);
    chk("to_error", int'(error_out), 1);
    chk("to_display", int'(display_out), 'h5C);
    chk("to_no_done", int'(cmd_done_out), 0);
    drive(1, 15);
    chk("clr_error", int'(error_out), 0);
    chk("clr_zero", int'(zero_out), 1);
    chk("clr_display", int'(display_out), 0);

    drive(0, 0);
    drive(1, 11);
    chk("ill_error", int'(error_out), 1);
    chk("ill_no_done", int'(cmd_done_out), 0);
    chk("ill_idle", int'(busy_out), 0);
    drive(1, 15);
    drive(1, 1);
    repeat (T - 1) drive(0, 0);
    drive(1, 7);
    chk("edge_led", int'(led_out), 7);
    chk("edge_no_err", int'(error_out), 0);
    chk("edge_done", int'(cmd_done_out), 1);

    drive(1, 1);
    reset_n = 1'b0;
    drive(0, 0); drive(0, 0);
    reset_n = 1'b1;
    drive(1, 4);
    chk("mid_rst_res", int'(result_out), 0);
    chk("mid_rst_zero", int'(zero_out), 1);
    chk("mid_rst_led", int'(led_out), 0);
    chk("mid_rst_done", int'(cmd_done_out), 1);
    chk("mid_rst_busy", int'(busy_out), 0);
    drive(0, 0);

    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        reset_n = 1'b0;
        drive(0, 0); drive(0, 0);
        reset_n = 1'b1;
      end else if (r < 5) begin
        repeat ($urandom_range(T - 3, T + 2)) drive(0, 0);
      end else if (r < 45) begin
        drive(0, 0);
      end else begin
        int p;
        int n;
        p = $urandom_range(0, 99);
        if (p < 8) n = $urandom_range(10, 14);
        else if (p < 13) n = 15;
        else n = $urandom_range(0, 9);
        drive(1, n);
      end
    end
    drive(0, 0);
    drive(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
